// File: rtl/kim_if_stage.sv
// Instruction-fetch stage: PC register, IF/ID pipeline register and taken-branch counter.
// A one-cycle BOOT state after reset precedes normal RUN fetching.
module kim_if_stage #(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(32'h0000_0000)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall,
  input  logic                  is_same,
  input  logic [ADDR_WIDTH-1:0] branch_target,
  input  logic [ADDR_WIDTH-1:0] imem_inst,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [ADDR_WIDTH-1:0] if_id_inst,
  output logic [ADDR_WIDTH-1:0] if_id_pc4,
  output logic                  if_id_valid,
  output logic [15:0]           br_taken_cnt
);

  localparam int unsigned           CNT_W   = 16;
  localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(4);
  localparam logic [CNT_W-1:0]      CNT_MAX = '1;
  localparam logic [CNT_W-1:0]      CNT_ONE = CNT_W'(1);

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   pc;
  logic [ADDR_WIDTH-1:0]   pc_plus4;
  logic [ADDR_WIDTH-1:0]   target_aligned;
  logic                    unused_target_lsbs;

  // Sequential increment wraps naturally at the top of the address space.
  assign pc_plus4       = pc + PC_STEP;
  assign target_aligned = {branch_target[ADDR_WIDTH-1:2], 2'b00};
  assign unused_target_lsbs = ^branch_target[1:0];

  assign imem_addr = pc;

  // Stall outranks a taken branch; a taken branch squashes the delay-slot fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= BOOT;
      pc           <= RESET_PC;
      if_id_inst   <= '0;
      if_id_pc4    <= '0;
      if_id_valid  <= 1'b0;
      br_taken_cnt <= '0;
    end else begin
      case (state)
        BOOT: begin
          state       <= RUN;
          pc          <= RESET_PC;
          if_id_inst  <= '0;
          if_id_pc4   <= '0;
          if_id_valid <= 1'b0;
        end
        RUN: begin
          if (stall) begin
            state <= RUN;
          end else if (is_same) begin
            pc          <= target_aligned;
            if_id_inst  <= '0;
            if_id_pc4   <= '0;
            if_id_valid <= 1'b0;
            if (br_taken_cnt != CNT_MAX) begin
              br_taken_cnt <= br_taken_cnt + CNT_ONE;
            end
          end else begin
            pc          <= pc_plus4;
            if_id_inst  <= imem_inst;
            if_id_pc4   <= pc_plus4;
            if_id_valid <= 1'b1;
          end
        end
        default: state <= BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_kim_if_stage.sv
// Self-checking bench for kim_if_stage: directed scenarios plus random stall/branch traffic
// compared against a cycle-level behavioural model of the fetch stage.
module tb_kim_if_stage;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        is_same;
  logic [31:0] branch_target;
  logic [31:0] imem_inst;
  logic [31:0] imem_addr;
  logic [31:0] if_id_inst;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
  logic [15:0] br_taken_cnt;

  int n_cmp;
  int n_fail;

  // Behavioural model state
  logic        m_boot;
  logic [31:0] m_pc;
  logic [31:0] m_inst;
  logic [31:0] m_pc4;
  logic        m_valid;
  logic [15:0] m_cnt;

  kim_if_stage #(.ADDR_WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .is_same      (is_same),
    .branch_target(branch_target),
    .imem_inst    (imem_inst),
    .imem_addr    (imem_addr),
    .if_id_inst   (if_id_inst),
    .if_id_pc4    (if_id_pc4),
    .if_id_valid  (if_id_valid),
    .br_taken_cnt (br_taken_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory image: each word is its address xor a fixed pattern.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction
  assign imem_inst = mem_word(imem_addr);

  function automatic logic [112:0] dut_vec();
    return {imem_addr, if_id_inst, if_id_pc4, if_id_valid, br_taken_cnt};
  endfunction

  function automatic logic [112:0] mdl_vec();
    return {m_pc, m_inst, m_pc4, m_valid, m_cnt};
  endfunction

  task automatic model_reset();
    m_boot = 1'b1; m_pc = 32'h0; m_inst = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0; m_cnt = 16'h0;
  endtask

  // One clock edge: the model applies the fetch rules to the inputs held across the edge.
  task automatic tick();
    @(posedge clk);
    if (m_boot) begin
      m_boot = 1'b0; m_inst = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
    end else if (stall) begin
      m_boot = 1'b0;
    end else if (is_same) begin
      m_pc = branch_target & 32'hFFFF_FFFC;
      m_inst = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    end else begin
      m_inst = mem_word(m_pc); m_pc4 = m_pc + 32'd4; m_valid = 1'b1; m_pc = m_pc + 32'd4;
    end
    #1;
  endtask

  task automatic drive(input logic s, input logic b, input logic [31:0] t);
    stall = s; is_same = b; branch_target = t;
  endtask

  task automatic test_reset();
    drive(1'b0, 1'b0, 32'h0);
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (dut_vec() !== mdl_vec()) begin
      n_fail++; $display("FAIL reset_state: got %h exp %h", dut_vec(), mdl_vec());
    end
  endtask

  task automatic test_boot();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if (dut_vec() !== {32'h0, 32'h0, 32'h0, 1'b0, 16'h0}) begin
      n_fail++; $display("FAIL boot_hold: got %h exp pc=0 bubble", dut_vec());
    end
    tick();
    n_cmp++;
    if (dut_vec() !== {32'h4, mem_word(32'h0), 32'h4, 1'b1, 16'h0}) begin
      n_fail++; $display("FAIL first_fetch: got %h exp pc4=4 valid=1", dut_vec());
    end
  endtask

  task automatic test_sequential();
    for (int i = 2; i <= 3; i++) begin
      tick();
      n_cmp++;
      if ({if_id_pc4, if_id_inst, if_id_valid} !== {32'(4 * i), mem_word(32'(4 * (i - 1))), 1'b1}) begin
        n_fail++; $display("FAIL seq_fetch%0d: got pc4=%h inst=%h v=%b", i, if_id_pc4, if_id_inst, if_id_valid);
      end
    end
  endtask

  task automatic test_branch();
    while (m_pc != 32'h10) tick();
    drive(1'b0, 1'b1, 32'h40);
    tick();
    n_cmp++;
    if ({imem_addr, if_id_valid, br_taken_cnt} !== {32'h40, 1'b0, 16'd1}) begin
      n_fail++; $display("FAIL branch_taken: got pc=%h v=%b cnt=%h exp pc=40 v=0 cnt=1", imem_addr, if_id_valid, br_taken_cnt);
    end
    drive(1'b0, 1'b0, 32'h0);
    tick();
    n_cmp++;
    if ({if_id_pc4, if_id_inst, if_id_valid} !== {32'h44, mem_word(32'h40), 1'b1}) begin
      n_fail++; $display("FAIL branch_target_fetch: got pc4=%h inst=%h v=%b exp pc4=44", if_id_pc4, if_id_inst, if_id_valid);
    end
  endtask

  task automatic test_stall_priority();
    logic [112:0] frozen;
    drive(1'b0, 1'b1, 32'h20);
    tick();
    tick();
    frozen = mdl_vec();
    drive(1'b1, 1'b1, 32'h80);
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (dut_vec() !== frozen) begin
        n_fail++; $display("FAIL stall_freeze%0d: got %h exp %h", i, dut_vec(), frozen);
      end
    end
    drive(1'b0, 1'b0, 32'h0);
    tick();
    n_cmp++;
    if (imem_addr !== 32'h24) begin
      n_fail++; $display("FAIL stall_release: got pc=%h exp 24", imem_addr);
    end
  endtask

  task automatic test_wrap_align();
    drive(1'b0, 1'b1, 32'h0000_0103);
    tick();
    n_cmp++;
    if (imem_addr !== 32'h0000_0100) begin
      n_fail++; $display("FAIL align: got pc=%h exp 00000100", imem_addr);
    end
    drive(1'b0, 1'b1, 32'hFFFF_FFFE);
    tick();
    drive(1'b0, 1'b0, 32'h0);
    tick();
    n_cmp++;
    if ({imem_addr, if_id_pc4, if_id_inst} !== {32'h0, 32'h0, mem_word(32'hFFFF_FFFC)}) begin
      n_fail++; $display("FAIL wrap: got pc=%h pc4=%h inst=%h exp pc=0 pc4=0", imem_addr, if_id_pc4, if_id_inst);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(99) < 25), ($urandom_range(99) < 30), $urandom);
      tick();
      n_cmp++;
      if (dut_vec() !== mdl_vec()) begin
        n_fail++; $display("FAIL random_cycle%0d: got %h exp %h", i, dut_vec(), mdl_vec());
      end
    end
    drive(1'b0, 1'b0, 32'h0);
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 65540; i++) begin
      drive(1'b0, 1'b1, 32'(i * 4));
      tick();
    end
    n_cmp++;
    if (br_taken_cnt !== 16'hFFFF) begin
      n_fail++; $display("FAIL cnt_saturate: got cnt=%h exp ffff", br_taken_cnt);
    end
    tick();
    n_cmp++;
    if (dut_vec() !== mdl_vec()) begin
      n_fail++; $display("FAIL cnt_hold_sat: got %h exp %h", dut_vec(), mdl_vec());
    end
    drive(1'b0, 1'b0, 32'h0);
    tick();
  endtask

  task automatic test_reset_mid();
    drive(1'b0, 1'b1, 32'h0000_0200);
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #1;
    n_cmp++;
    if (dut_vec() !== {32'h0, 32'h0, 32'h0, 1'b0, 16'h0}) begin
      n_fail++; $display("FAIL reset_async: got %h exp all zero", dut_vec());
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (dut_vec() !== mdl_vec()) begin
      n_fail++; $display("FAIL reset_held: got %h exp %h", dut_vec(), mdl_vec());
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if (dut_vec() !== {32'h0, 32'h0, 32'h0, 1'b0, 16'h0}) begin
      n_fail++; $display("FAIL reset_boot_replay: got %h exp pc=0 bubble (is_same ignored)", dut_vec());
    end
    drive(1'b0, 1'b0, 32'h0);
    tick();
    n_cmp++;
    if (dut_vec() !== {32'h4, mem_word(32'h0), 32'h4, 1'b1, 16'h0}) begin
      n_fail++; $display("FAIL reset_refetch: got %h exp pc4=4 valid=1", dut_vec());
    end
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    test_reset();
    test_boot();
    test_sequential();
    test_branch();
    test_stall_priority();
    test_wrap_align();
    test_random();
    test_saturation();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
